// File: rtl/starflux_pkg.sv
// ---------------------------------------------------------------------------
// starflux_pkg
//   Shared types and constants for the starflux game blocks.
//   - Screen geometry (SCREEN_W x SCREEN_H) and coordinate widths.
//   - Gun fire controller FSM state encoding.
//   - spawn_row(): row one above the ship, clamped at the top edge.
// ---------------------------------------------------------------------------
package starflux_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W      = 8;   // column width, 0..159
    localparam int Y_W      = 7;   // row width, 0..119
    localparam int HEAT_W   = 4;
    localparam int CNT_W    = 28;  // fire interval counter width
    localparam int SHOT_W   = 8;   // shot counter width

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_COOLDOWN = 2'd2
    } gun_state_e;

    // Projectiles start one row above the ship; row 0 has nothing above it,
    // so stay on row 0 instead of wrapping to the bottom of the screen.
    function automatic logic [Y_W-1:0] spawn_row(input logic [Y_W-1:0] y);
        return (y == '0) ? '0 : y - Y_W'(1);
    endfunction

endpackage

// File: rtl/fire_interval_timer.sv
// ---------------------------------------------------------------------------
// fire_interval_timer
//   Loadable down-counter that enforces the gap between accepted shots.
//   It restarts on every shot, so it cannot share the free-running divider.
//   Ports:
//     clock, resetn   clock / async active-low reset
//     clear_i         synchronous clear to 0 (highest priority)
//     load_i          load load_val_i this cycle
//     load_val_i      interval length in cycles
//     done_o          counter has reached 0
// ---------------------------------------------------------------------------
module fire_interval_timer
    import starflux_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);   // parks at 0 until the next load
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/gun_fire_controller.sv
// ---------------------------------------------------------------------------
// gun_fire_controller
//   Turns the shoot switch into projectile spawn requests (ready/valid),
//   with a minimum interval between shots and a heat lockout with
//   hysteresis.
//   Ports:
//     clock, resetn        50 MHz clock / async active-low reset
//     startGameEn          synchronous restart, clears all state
//     shoot                fire request level
//     heat                 current gun heat 0..15
//     ship_x, ship_y       ship position
//     spawn_valid/_ready   spawn handshake with the projectile engine
//     spawn_x, spawn_y     projectile start position, stable while valid
//     overheated           lockout flag
//     shots_fired          accepted shots, saturating at 255
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module gun_fire_controller
    import starflux_pkg::*;
#(
    parameter logic [CNT_W-1:0]  FIRE_INTERVAL = 28'd12_499_999,
    parameter logic [HEAT_W-1:0] HEAT_MAX      = 4'd15,
    parameter logic [HEAT_W-1:0] RESUME_LEVEL  = 4'd8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              startGameEn,
    input  logic              shoot,
    input  logic [HEAT_W-1:0] heat,
    input  logic [X_W-1:0]    ship_x,
    input  logic [Y_W-1:0]    ship_y,
    output logic              spawn_valid,
    output logic [X_W-1:0]    spawn_x,
    output logic [Y_W-1:0]    spawn_y,
    input  logic              spawn_ready,
    output logic              overheated,
    output logic [SHOT_W-1:0] shots_fired
);

    gun_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    logic [X_W-1:0]    sx_q, sx_d;
    logic [Y_W-1:0]    sy_q, sy_d;
    logic              oh_q, oh_d;
    logic [SHOT_W-1:0] shots_q, shots_d;
    logic              tmr_load, tmr_done;

    fire_interval_timer #(.W(CNT_W)) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .clear_i    (startGameEn),
        .load_i     (tmr_load),
        .load_val_i (FIRE_INTERVAL),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        oh_d     = oh_q;
        shots_d  = shots_q;
        tmr_load = 1'b0;

        unique case (state_q)
            // Gate on the registered lockout: a request seen on the same
            // edge that heat hits the limit still goes out.
            ST_IDLE: begin
                if (shoot && !oh_q) begin
                    state_d = ST_REQ;
                    sx_d    = ship_x;
                    sy_d    = spawn_row(ship_y);
                end
            end
            // Once raised, a request is only retired by the handshake.
            ST_REQ: begin
                if (spawn_ready) begin
                    state_d  = ST_COOLDOWN;
                    tmr_load = 1'b1;
                    if (shots_q != '1)
                        shots_d = shots_q + SHOT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (tmr_done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Hysteresis: set at the limit, release at the resume level, hold in
        // between. Set is checked first so it wins if both ever overlap.
        if (heat == HEAT_MAX)
            oh_d = 1'b1;
        else if (heat <= RESUME_LEVEL)
            oh_d = 1'b0;

        if (startGameEn) begin
            state_d  = ST_IDLE;
            shots_d  = '0;
            oh_d     = 1'b0;
            tmr_load = 1'b0;
        end

        // Valid is a flop copy of "next state is REQ" so it has no
        // combinational path from the inputs.
        valid_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            oh_q    <= 1'b0;
            shots_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            oh_q    <= oh_d;
            shots_q <= shots_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_x     = sx_q;
    assign spawn_y     = sy_q;
    assign overheated  = oh_q;
    assign shots_fired = shots_q;

endmodule

// File: tb/tb_gun_fire_controller.sv
module tb_gun_fire_controller;

    logic       clock;
    logic       resetn;
    logic       startGameEn;
    logic       shoot;
    logic [3:0] heat;
    logic [7:0] ship_x;
    logic [6:0] ship_y;
    logic       spawn_valid;
    logic [7:0] spawn_x;
    logic [6:0] spawn_y;
    logic       spawn_ready;
    logic       overheated;
    logic [7:0] shots_fired;

    gun_fire_controller #(
        .FIRE_INTERVAL (28'd3),
        .HEAT_MAX      (4'd15),
        .RESUME_LEVEL  (4'd8)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .startGameEn (startGameEn),
        .shoot       (shoot),
        .heat        (heat),
        .ship_x      (ship_x),
        .ship_y      (ship_y),
        .spawn_valid (spawn_valid),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_ready (spawn_ready),
        .overheated  (overheated),
        .shots_fired (shots_fired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
    } spawn_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] ex;
        logic [6:0] ey;
    } cvec_t;

    typedef struct {
        logic [3:0] h;
        logic       oh;
    } hvec_t;

    int     checks = 0;
    int     errors = 0;
    spawn_t sb_q[$];
    spawn_t exp_s;
    int     model_shots = 0;
    logic   prev_valid = 1'b0;
    cvec_t  cvec[4];
    hvec_t  hvec[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic push(input logic [7:0] x, input logic [6:0] y);
        spawn_t s;
        s.x = x;
        s.y = y;
        sb_q.push_back(s);
    endtask

    initial begin
        resetn = 1'b0; startGameEn = 1'b0; shoot = 1'b0; heat = 4'd0;
        ship_x = 8'd0; ship_y = 7'd0; spawn_ready = 1'b0;

        // Scoreboard: each new spawn request pops the expected coordinates;
        // observed handshakes feed a saturating shot-count model.
        fork
            forever begin
                @(negedge clock);
                if (!resetn) model_shots = 0;
                chk("shots_fired", shots_fired, model_shots);
                if (spawn_valid && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_spawn: got (%0d,%0d) expected none at %0t",
                                 spawn_x, spawn_y, $time);
                    end else begin
                        exp_s = sb_q.pop_front();
                        chk("sb_spawn_x", spawn_x, exp_s.x);
                        chk("sb_spawn_y", spawn_y, exp_s.y);
                    end
                end
                prev_valid = spawn_valid;
                if (!resetn || startGameEn)
                    model_shots = 0;
                else if (spawn_valid && spawn_ready && model_shots != 255)
                    model_shots++;
            end
        join_none

        cvec[0] = '{8'd0,   7'd0,   8'd0,   7'd0};
        cvec[1] = '{8'd159, 7'd119, 8'd159, 7'd118};
        cvec[2] = '{8'd80,  7'd1,   8'd80,  7'd0};
        cvec[3] = '{8'd7,   7'd64,  8'd7,   7'd63};

        hvec[0] = '{4'd14, 1'b0};
        hvec[1] = '{4'd15, 1'b1};
        hvec[2] = '{4'd12, 1'b1};
        hvec[3] = '{4'd9,  1'b1};
        hvec[4] = '{4'd8,  1'b0};
        hvec[5] = '{4'd13, 1'b0};
        hvec[6] = '{4'd15, 1'b1};
        hvec[7] = '{4'd15, 1'b1};
        hvec[8] = '{4'd0,  1'b0};

        // Reset values
        repeat (3) @(posedge clock);
        #2;
        chk("rst_valid", spawn_valid, 0);
        chk("rst_x", spawn_x, 0);
        chk("rst_y", spawn_y, 0);
        chk("rst_overheated", overheated, 0);
        chk("rst_shots", shots_fired, 0);
        resetn = 1'b1;
        cyc();

        // Auto-fire with ready held high: 1-cycle pulses every 6 cycles
        ship_x = 8'd80; ship_y = 7'd100; spawn_ready = 1'b1;
        repeat (3) push(8'd80, 7'd99);
        shoot = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk("autofire_valid", spawn_valid, ((k % 6) == 1) ? 1 : 0);
        end
        chk("autofire_shots", shots_fired, 3);
        shoot = 1'b0;
        repeat (8) cyc();

        // Ready stalled: request and coordinates hold, dropping shoot is harmless
        spawn_ready = 1'b0; ship_x = 8'd40; ship_y = 7'd50;
        push(8'd40, 7'd49);
        shoot = 1'b1;
        cyc();
        chk("stall_valid_rise", spawn_valid, 1);
        shoot = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ship_x = 8'(i * 13 + 1);
            cyc();
            chk("stall_valid", spawn_valid, 1);
            chk("stall_x", spawn_x, 40);
            chk("stall_y", spawn_y, 49);
        end
        spawn_ready = 1'b1;
        cyc();
        chk("stall_valid_drop", spawn_valid, 0);
        chk("stall_shots", shots_fired, 4);
        repeat (8) cyc();

        // Coordinate capture table, including row-0 clamp
        for (int i = 0; i < 4; i++) begin
            ship_x = cvec[i].x; ship_y = cvec[i].y; spawn_ready = 1'b1;
            push(cvec[i].ex, cvec[i].ey);
            shoot = 1'b1;
            cyc();
            chk("tbl_valid", spawn_valid, 1);
            chk("tbl_x", spawn_x, cvec[i].ex);
            chk("tbl_y", spawn_y, cvec[i].ey);
            shoot = 1'b0;
            cyc();
            chk("tbl_valid_drop", spawn_valid, 0);
            repeat (6) cyc();
        end
        chk("tbl_shots", shots_fired, 8);

        // Heat hysteresis table (not firing)
        for (int i = 0; i < 9; i++) begin
            heat = hvec[i].h;
            cyc();
            chk("heat_tbl_overheated", overheated, hvec[i].oh);
        end

        // Lockout while holding shoot; request on the same edge as heat=15 is accepted
        ship_x = 8'd10; ship_y = 7'd10; spawn_ready = 1'b1;
        heat = 4'd15; shoot = 1'b1;
        push(8'd10, 7'd9);
        cyc();
        chk("lock_same_edge_valid", spawn_valid, 1);
        chk("lock_overheated", overheated, 1);
        heat = 4'd12;
        cyc();
        chk("lock_hs_drop", spawn_valid, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("lock_blocked_valid", spawn_valid, 0);
            chk("lock_hold_overheated", overheated, 1);
        end
        heat = 4'd8;
        push(8'd10, 7'd9);
        cyc();
        chk("lock_release", overheated, 0);
        chk("lock_release_valid", spawn_valid, 0);
        cyc();
        chk("lock_resume_valid", spawn_valid, 1);
        shoot = 1'b0; heat = 4'd0;
        repeat (8) cyc();
        chk("lock_shots", shots_fired, 10);

        // Saturation: 300 accepted shots from row 0
        ship_x = 8'd5; ship_y = 7'd0; spawn_ready = 1'b1;
        repeat (300) push(8'd5, 7'd0);
        shoot = 1'b1;
        for (int k = 1; k <= 1795; k++) cyc();
        shoot = 1'b0;
        repeat (8) cyc();
        chk("sat_shots", shots_fired, 255);
        chk("sat_spawn_y", spawn_y, 0);
        chk("sat_queue_drained", sb_q.size(), 0);

        // startGameEn during REQ with ready high: clear wins
        heat = 4'd15;
        cyc();
        heat = 4'd10;
        cyc();
        chk("sg_pre_overheated", overheated, 1);
        heat = 4'd0;
        cyc();
        chk("sg_pre_cleared", overheated, 0);
        heat = 4'd15;
        cyc();
        heat = 4'd10;
        ship_x = 8'd20; ship_y = 7'd30; spawn_ready = 1'b1;
        push(8'd20, 7'd29);
        shoot = 1'b1;
        // overheated is set, so re-arm with the registered flag low first
        chk("sg_blocked_valid", spawn_valid, 0);
        heat = 4'd0;
        cyc();
        cyc();
        chk("sg_req_valid", spawn_valid, 1);
        heat = 4'd15;
        startGameEn = 1'b1;
        cyc();
        chk("sg_valid", spawn_valid, 0);
        chk("sg_shots", shots_fired, 0);
        chk("sg_overheated", overheated, 0);
        startGameEn = 1'b0; heat = 4'd10;
        push(8'd20, 7'd29);
        cyc();
        chk("sg_idle_refire", spawn_valid, 1);
        shoot = 1'b0;
        cyc();
        chk("sg_refire_shots", shots_fired, 1);

        // Async reset mid-COOLDOWN
        cyc();
        heat = 4'd15;
        cyc();
        chk("ar_pre_overheated", overheated, 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("ar_valid", spawn_valid, 0);
        chk("ar_x", spawn_x, 0);
        chk("ar_y", spawn_y, 0);
        chk("ar_overheated", overheated, 0);
        chk("ar_shots", shots_fired, 0);
        cyc();
        resetn = 1'b1; heat = 4'd0;
        repeat (3) cyc();
        chk("end_queue_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gun_fire_controller.md
# gun_fire_controller

Consumer of the 4-bit gun heat level. Turns the player's `shoot` switch into discrete projectile spawn requests for the projectile/draw engine, using a ready/valid handshake. Enforces a minimum interval between shots and an overheat lockout with hysteresis driven by `heat`. Sits between the heat counter, the ship position registers and the projectile engine.

## Interface
- `FIRE_INTERVAL`, 28'd12_499_999: cycles of enforced gap after each accepted shot (4 shots/s at 50 MHz).
- `HEAT_MAX`, 4'd15: heat level that triggers lockout.
- `RESUME_LEVEL`, 4'd8: heat level at or below which lockout releases.
- `clock`  in  1  50 MHz system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `startGameEn`  in  1  synchronous game restart; clears all state.
- `shoot`  in  1  fire request level, SW[0].
- `heat`  in  4  current gun heat, 0..15.
- `ship_x`  in  8  ship column, 0..159.
- `ship_y`  in  7  ship row, 0..119.
- `spawn_valid`  out  1  spawn request pending.
- `spawn_x`  out  8  projectile start column.
- `spawn_y`  out  7  projectile start row.
- `spawn_ready`  in  1  projectile engine accepts the request.
- `overheated`  out  1  lockout active; drives LED/HUD.
- `shots_fired`  out  8  accepted shots since start, saturating.

## Operation
- FSM states: IDLE, REQ, COOLDOWN.
- IDLE: if `shoot` && !`overheated`, capture coordinates and go to REQ.
  - `spawn_x` = `ship_x`.
  - `spawn_y` = `ship_y` − 1. If `ship_y` is 0, `spawn_y` = 0.
- REQ: `spawn_valid` = 1, with `spawn_x`/`spawn_y` stable.
  - Hold until `spawn_ready` is sampled high.
  - On the handshake cycle: `shots_fired` += 1 (saturates at 255), load interval counter with `FIRE_INTERVAL`, go to COOLDOWN.
  - Dropping `shoot` or becoming overheated does not cancel a pending request.
- COOLDOWN: decrement counter each cycle; at 0 go to IDLE.
  - `FIRE_INTERVAL` = 0 means exactly one COOLDOWN cycle.
- Holding `shoot` gives auto-fire at one shot per (handshake latency + `FIRE_INTERVAL` + 2) cycles.
- Lockout register `overheated`:
  - Set when `heat` == `HEAT_MAX`.
  - Cleared when `heat` <= `RESUME_LEVEL`.
  - Otherwise holds (hysteresis). Evaluated every cycle in every state.
- `startGameEn` has top priority. It synchronously forces IDLE, `spawn_valid` 0, counter 0, `shots_fired` 0 and `overheated` 0.
- Arithmetic:
  - Interval counter is 28-bit unsigned.
  - `spawn_y` subtraction must not wrap.
  - `shots_fired` never wraps.

## Timing
- Reset values: state IDLE; `spawn_valid` 0; `spawn_x` 0; `spawn_y` 0; `overheated` 0; `shots_fired` 0.
- Latency:
  - `shoot` high in IDLE at edge N → `spawn_valid` high after edge N.
  - `spawn_ready` sampled high at edge M → `spawn_valid` low after edge M; the transfer counts once.
- `spawn_ready` high while `spawn_valid` is low is ignored.
- Ready may be held high permanently: that gives a one-cycle valid pulse.
- Lockout:
  - `heat` reaching 15 at edge K → `overheated` 1 after K.
  - A shoot request sampled at edge K itself is still accepted, because the check uses the registered `overheated`.
- `heat` == `HEAT_MAX` and <= `RESUME_LEVEL` cannot both hold while `RESUME_LEVEL` < `HEAT_MAX`. If parameterised so that both hold, set wins.
- `startGameEn` together with handshake: the clear wins and `shots_fired` ends at 0.
- `resetn` asserted mid-REQ drops `spawn_valid` immediately (asynchronously).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `starflux_pkg`:
  - FSM state typedef.
  - Screen constants `SCREEN_W`=160 and `SCREEN_H`=120.
  - Coordinate widths (8 and 7).
- Sub-module `fire_interval_timer`:
  - Loadable 28-bit down-counter with async active-low reset.
  - Ports: load, load value, clear, `done` flag.
  - Separate from the free-running rate divider because it must restart on each shot.

## Test plan
- Reset, then `shoot`=1, `ship_x`=80, `ship_y`=100, `spawn_ready`=1, `FIRE_INTERVAL`=3 → `spawn_valid` pulses 1 cycle with (80,99); next pulse 6 cycles later; `shots_fired` increments each pulse.
- `spawn_ready` held 0 for 10 cycles after `spawn_valid` rises → valid and coordinates stay stable; changing `ship_x` has no effect; one count on the eventual ready.
- `heat` steps 14→15→12→8 with `shoot` held → `overheated` 1 from the cycle after 15; stays 1 at 12; clears after 8; firing resumes.
- `ship_y`=0 → `spawn_y`=0. 300 accepted shots → `shots_fired`=255.
- `startGameEn` pulsed during REQ with `spawn_ready` high → `spawn_valid` 0, `shots_fired` 0, `overheated` 0, state IDLE.
- `resetn` asserted low mid-COOLDOWN → all outputs return to reset values without a clock edge.
